// File: rtl/mii_pkg.sv
// Shared definitions for the MII receive path: framer state encoding and
// the preamble/SFD byte values seen after nibble assembly.
package mii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_FLUSH,
    ST_DROP
  } rx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         mii_clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge mii_clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mii_rx_framer.sv
// Receive frame sequencer: strips preamble/SFD, delimits frames through a
// one-byte hold register, enforces length/nibble alignment, counts frames.
module mii_rx_framer
  import mii_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = 11,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             mii_clk,
  input  logic             reset,
  input  logic             mii_en,
  input  logic             byte_rdy,
  input  logic [7:0]       byte_q,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic             rx_err,
  output logic [LEN_W-1:0] frame_len,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_err
);

  rx_state_t        state;
  logic [7:0]       hold;
  logic             hold_full;
  logic             first;
  logic             seen_pre;
  logic             parity;
  logic [LEN_W-1:0] len;

  logic over;
  logic end_quiet;
  logic fin;
  logic fin_bad;
  logic inc_ok;
  logic inc_err;

  // Frame completion is decided combinationally so the counters step on the
  // same edge that registers rx_eof.
  always_comb begin
    over      = (state == ST_DATA) && byte_rdy && (len == LEN_W'(MAX_LEN));
    end_quiet = (state == ST_DATA) && !mii_en && !byte_rdy;
    fin       = over || end_quiet || (state == ST_FLUSH);
    fin_bad   = over || (len < LEN_W'(MIN_LEN)) || parity;
    inc_ok    = fin && !fin_bad && !reset;
    inc_err   = fin && fin_bad && !reset;
  end

  always_ff @(posedge mii_clk) begin
    if (reset) begin
      state     <= ST_DROP;
      hold      <= '0;
      hold_full <= 1'b0;
      first     <= 1'b0;
      seen_pre  <= 1'b0;
      parity    <= 1'b0;
      len       <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      rx_sof    <= 1'b0;
      rx_eof    <= 1'b0;
      rx_err    <= 1'b0;
      frame_len <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_sof   <= 1'b0;
      rx_eof   <= 1'b0;
      rx_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          parity    <= 1'b0;
          seen_pre  <= 1'b0;
          hold_full <= 1'b0;
          first     <= 1'b1;
          len       <= '0;
          if (mii_en) begin
            parity <= 1'b1;
            state  <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (!mii_en) begin
            state <= ST_IDLE;
          end else begin
            parity <= ~parity;
            if (byte_rdy) begin
              if (byte_q == PREAMBLE_BYTE) begin
                seen_pre <= 1'b1;
              end else if ((byte_q == SFD_BYTE) && seen_pre) begin
                state <= ST_DATA;
              end else begin
                state <= ST_DROP;
              end
            end
          end
        end
        ST_DATA: begin
          if (mii_en) begin
            parity <= ~parity;
          end
          if (over) begin
            rx_valid  <= 1'b1;
            rx_data   <= hold;
            rx_sof    <= first;
            rx_eof    <= 1'b1;
            rx_err    <= 1'b1;
            frame_len <= len;
            state     <= ST_DROP;
          end else if (byte_rdy) begin
            if (hold_full) begin
              rx_valid <= 1'b1;
              rx_data  <= hold;
              rx_sof   <= first;
              first    <= 1'b0;
            end
            hold      <= byte_q;
            hold_full <= 1'b1;
            len       <= len + 1'b1;
            if (!mii_en) begin
              state <= ST_FLUSH;
            end
          end else if (!mii_en) begin
            if (hold_full) begin
              rx_valid <= 1'b1;
              rx_data  <= hold;
              rx_sof   <= first;
              rx_eof   <= 1'b1;
              rx_err   <= fin_bad;
            end
            frame_len <= len;
            state     <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          rx_valid  <= 1'b1;
          rx_data   <= hold;
          rx_sof    <= first;
          rx_eof    <= 1'b1;
          rx_err    <= fin_bad;
          frame_len <= len;
          state     <= ST_IDLE;
        end
        ST_DROP: begin
          if (!mii_en) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_DROP;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_ok_cnt (
    .mii_clk (mii_clk),
    .clr     (reset),
    .inc     (inc_ok),
    .count   (frames_ok)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .mii_clk (mii_clk),
    .clr     (reset),
    .inc     (inc_err),
    .count   (frames_err)
  );

endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench for mii_rx_framer: expected beats are queued as bytes are
// driven and matched against the output stream by a monitor.
module tb_mii_rx_framer;

  localparam int MIN_L = 64;
  localparam int MAX_L = 1518;

  logic        mii_clk;
  logic        reset;
  logic        mii_en;
  logic        byte_rdy;
  logic [7:0]  byte_q;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_sof;
  logic        rx_eof;
  logic        rx_err;
  logic [10:0] frame_len;
  logic [15:0] frames_ok;
  logic [15:0] frames_err;

  mii_rx_framer #(
    .MIN_LEN (64),
    .MAX_LEN (1518),
    .LEN_W   (11),
    .CNT_W   (16)
  ) dut (
    .mii_clk    (mii_clk),
    .reset      (reset),
    .mii_en     (mii_en),
    .byte_rdy   (byte_rdy),
    .byte_q     (byte_q),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_sof     (rx_sof),
    .rx_eof     (rx_eof),
    .rx_err     (rx_err),
    .frame_len  (frame_len),
    .frames_ok  (frames_ok),
    .frames_err (frames_err)
  );

  initial mii_clk = 1'b0;
  always #5 mii_clk = ~mii_clk;

  typedef struct {
    logic [7:0]  data;
    logic        sof;
    logic        eof;
    logic        err;
    logic [10:0] len;
    logic [15:0] ok;
    logic [15:0] bad;
  } beat_t;

  beat_t       sb[$];
  int          checks;
  int          errors;
  int          m_ok;
  int          m_bad;
  int          m_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic rdy, input logic [7:0] q);
    mii_en   = en;
    byte_rdy = rdy;
    byte_q   = q;
    @(posedge mii_clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, rx_valid, 0);
    chk({tag, "_data"},  rx_data, 0);
    chk({tag, "_sof"},   rx_sof, 0);
    chk({tag, "_eof"},   rx_eof, 0);
    chk({tag, "_err"},   rx_err, 0);
    chk({tag, "_len"},   frame_len, 0);
    chk({tag, "_ok"},    frames_ok, 0);
    chk({tag, "_bad"},   frames_err, 0);
  endtask

  // Drives one frame as nibble cycles; with lag the byte strobe trails the
  // second nibble by a cycle so the final strobe lands on the mii_en fall.
  task automatic send_frame(input int npre, input logic [7:0] sfd, input int n,
                            input bit lag, input bit extra, input int reset_at);
    logic [7:0] bytes[$];
    bit         good;
    int         last;
    good = (sfd == 8'hD5) && (npre > 0);
    last = (n < MAX_L) ? n : MAX_L;
    for (int i = 0; i < npre; i++) bytes.push_back(8'h55);
    bytes.push_back(sfd);
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom_range(0, 255)));

    for (int i = 0; i <= bytes.size(); i++) begin
      int  idx;
      bit  do_rdy;
      bit  en;
      if (i == bytes.size() && !lag) break;
      idx    = lag ? i - 1 : i;
      en     = (i < bytes.size());
      do_rdy = (idx >= 0);
      if (i < bytes.size() && !lag) begin
        step(1'b1, 1'b0, 8'h00);
      end
      if (extra && i == bytes.size() - 1 && !lag) begin
        ;
      end
      if (do_rdy) begin
        int  j;
        bit  rst_now;
        j       = idx - npre;
        rst_now = (reset_at > 0) && good && (j == reset_at);
        if (good && j >= 1 && ((reset_at == 0) ? (j <= MAX_L) : (j <= reset_at - 2))) begin
          beat_t b;
          b.data = bytes[idx];
          b.sof  = (j == 1);
          b.eof  = (reset_at == 0) && (j == last);
          b.err  = b.eof && ((n < MIN_L) || (n > MAX_L) || extra);
          if (b.eof) begin
            m_len = last;
            if (b.err) m_bad++; else m_ok++;
          end
          b.len = 11'(m_len);
          b.ok  = 16'(m_ok);
          b.bad = 16'(m_bad);
          sb.push_back(b);
        end
        if (rst_now) reset = 1'b1;
        if (lag && i < bytes.size()) begin
          step(1'b1, 1'b1, bytes[idx]);
        end else begin
          step(en, 1'b1, bytes[idx]);
        end
        if (rst_now) begin
          reset    = 1'b0;
          byte_rdy = 1'b0;
          m_ok     = 0;
          m_bad    = 0;
          m_len    = 0;
          @(negedge mii_clk);
          check_idle_outputs("midreset");
          chk("midreset_queue", sb.size(), 0);
        end
      end else if (lag && i < bytes.size()) begin
        step(1'b1, 1'b0, 8'h00);
      end
      if (lag && i < bytes.size()) step(1'b1, 1'b0, 8'h00);
    end
    if (extra) step(1'b1, 1'b0, 8'h00);
    if (!lag) step(1'b0, 1'b0, 8'h00);
    repeat (4) step(1'b0, 1'b0, 8'h00);
    if (good && n == 0 && reset_at == 0) begin
      m_bad++;
      m_len = 0;
    end
    @(negedge mii_clk);
    chk("after_frames_ok",  frames_ok, m_ok);
    chk("after_frames_err", frames_err, m_bad);
    chk("after_frame_len",  frame_len, m_len);
    chk("after_queue",      sb.size(), 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    m_ok     = 0;
    m_bad    = 0;
    m_len    = 0;
    reset    = 1'b1;
    mii_en   = 1'b0;
    byte_rdy = 1'b0;
    byte_q   = 8'h00;

    fork
      forever begin
        beat_t e;
        @(negedge mii_clk);
        if (rx_valid) begin
          if (sb.size() == 0) begin
            chk("spurious_valid", rx_valid, 0);
          end else begin
            e = sb.pop_front();
            chk("beat_data", rx_data, e.data);
            chk("beat_sof",  rx_sof, e.sof);
            chk("beat_eof",  rx_eof, e.eof);
            chk("beat_err",  rx_err, e.err);
            if (e.eof) begin
              chk("eof_frame_len",  frame_len, e.len);
              chk("eof_frames_ok",  frames_ok, e.ok);
              chk("eof_frames_err", frames_err, e.bad);
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge mii_clk);
    #1;
    @(negedge mii_clk);
    check_idle_outputs("reset");
    @(posedge mii_clk);
    #1;
    reset = 1'b0;
    repeat (3) step(1'b0, 1'b0, 8'h00);

    send_frame(7, 8'hD5, 64,   1'b0, 1'b0, 0);  // good frame
    send_frame(7, 8'hD5, 10,   1'b0, 1'b0, 0);  // runt
    send_frame(7, 8'hD5, 1519, 1'b0, 1'b0, 0);  // oversize
    send_frame(7, 8'hD5, 64,   1'b0, 1'b0, 0);
    send_frame(7, 8'hD5, 64,   1'b0, 1'b1, 0);  // dribble nibble
    send_frame(2, 8'h5D, 20,   1'b0, 1'b0, 0);  // corrupt preamble
    send_frame(0, 8'hD5, 20,   1'b0, 1'b0, 0);  // SFD without preamble
    send_frame(7, 8'hD5, 64,   1'b1, 1'b0, 0);  // strobe on mii_en fall
    send_frame(7, 8'hD5, 1,    1'b0, 1'b0, 0);
    send_frame(7, 8'hD5, 0,    1'b0, 1'b0, 0);
    send_frame(7, 8'hD5, 63,   1'b0, 1'b0, 0);
    send_frame(7, 8'hD5, 1518, 1'b0, 1'b0, 0);
    send_frame(7, 8'hD5, 64,   1'b0, 1'b0, 30); // reset mid-frame
    send_frame(7, 8'hD5, 64,   1'b0, 1'b0, 0);

    repeat (20) step(1'b0, 1'b0, 8'h00);
    chk("final_queue_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
